// File: rtl/decrypt_pkg.sv
// Shared SPECK128/128 cipher settings and decrypt FSM state encodings.
package decrypt_pkg;

    localparam int unsigned WORD_SIZE = 64;
    localparam int unsigned KEY_SIZE  = 2 * WORD_SIZE;
    localparam int unsigned NR_ROUNDS = 32;
    localparam int unsigned ALPHA     = 8;
    localparam int unsigned BETA      = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StExpand  = 2'd1,
        StDecrypt = 2'd2,
        StDone    = 2'd3
    } state_e;

endpackage

// File: rtl/decrypt_if.sv
// Request/result bundle of the decrypt core; master drives the request side.
interface decrypt_if #(
    parameter int unsigned WORD_SIZE = 64
);
    logic                     start;
    logic [2*WORD_SIZE-1:0]   ciphertext;
    logic [2*WORD_SIZE-1:0]   key;
    logic [2*WORD_SIZE-1:0]   plaintext;
    logic                     active;
    logic                     ready;

    modport master (output start, ciphertext, key, input plaintext, active, ready);
    modport slave  (input start, ciphertext, key, output plaintext, active, ready);
endinterface

// File: rtl/round_decrypt.sv
// One inverse SPECK round, purely combinational; exact inverse of round_encrypt.
module round_decrypt
    import decrypt_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 64
) (
    input  logic [WORD_SIZE-1:0] x,
    input  logic [WORD_SIZE-1:0] y,
    input  logic [WORD_SIZE-1:0] rk,
    output logic [WORD_SIZE-1:0] x_out,
    output logic [WORD_SIZE-1:0] y_out
);

    logic [WORD_SIZE-1:0] xy;
    logic [WORD_SIZE-1:0] diff;

    assign xy    = x ^ y;
    assign y_out = (xy >> BETA) | (xy << (WORD_SIZE - BETA));
    // Subtraction wraps modulo 2^WORD_SIZE, undoing the encrypt-side addition.
    assign diff  = (x ^ rk) - y_out;
    assign x_out = (diff << ALPHA) | (diff >> (WORD_SIZE - ALPHA));

endmodule

// File: rtl/decrypt.sv
// Iterative SPECK decryption: expands round keys into a local file, then runs
// the inverse rounds in reverse key order and pulses ready with the plaintext.
module decrypt
    import decrypt_pkg::*;
#(
    parameter int unsigned NR_ROUNDS = 32,
    parameter int unsigned WORD_SIZE = 64
) (
    input  logic     clk,
    input  logic     rst,
    decrypt_if.slave bus
);

    localparam int unsigned CtrW = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;
    localparam logic [CtrW-1:0] LastCtr = CtrW'(NR_ROUNDS - 1);

    state_e                   state_q, state_d;
    logic [CtrW-1:0]          ctr_q, ctr_d;
    logic [WORD_SIZE-1:0]     x_q, x_d, y_q, y_d, k_q, k_d, l_q, l_d;
    logic [2*WORD_SIZE-1:0]   pt_q, pt_d;
    logic                     active_q, active_d;
    logic                     ready_q, ready_d;
    logic                     rk_we;
    logic [WORD_SIZE-1:0]     rk [NR_ROUNDS];
    logic [WORD_SIZE-1:0]     rk_rd;
    logic [WORD_SIZE-1:0]     x_rnd, y_rnd;
    logic [WORD_SIZE-1:0]     ctr_ext, l_next, k_next;

    assign rk_rd   = rk[ctr_q];
    assign ctr_ext = {{(WORD_SIZE-CtrW){1'b0}}, ctr_q};
    assign l_next  = (k_q + ((l_q >> ALPHA) | (l_q << (WORD_SIZE - ALPHA)))) ^ ctr_ext;
    assign k_next  = ((k_q << BETA) | (k_q >> (WORD_SIZE - BETA))) ^ l_next;

    round_decrypt #(
        .WORD_SIZE (WORD_SIZE)
    ) u_round (
        .x     (x_q),
        .y     (y_q),
        .rk    (rk_rd),
        .x_out (x_rnd),
        .y_out (y_rnd)
    );

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        x_d      = x_q;
        y_d      = y_q;
        k_d      = k_q;
        l_d      = l_q;
        pt_d     = pt_q;
        active_d = active_q;
        ready_d  = 1'b0;
        rk_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    x_d      = bus.ciphertext[2*WORD_SIZE-1:WORD_SIZE];
                    y_d      = bus.ciphertext[WORD_SIZE-1:0];
                    k_d      = bus.key[2*WORD_SIZE-1:WORD_SIZE];
                    l_d      = bus.key[WORD_SIZE-1:0];
                    ctr_d    = '0;
                    active_d = 1'b1;
                    state_d  = StExpand;
                end
            end
            StExpand: begin
                rk_we = 1'b1;
                l_d   = l_next;
                k_d   = k_next;
                // ctr is left at the last index so decryption starts from the final key.
                if (ctr_q == LastCtr) state_d = StDecrypt;
                else                  ctr_d   = ctr_q + 1'b1;
            end
            StDecrypt: begin
                x_d = x_rnd;
                y_d = y_rnd;
                if (ctr_q == '0) state_d = StDone;
                else             ctr_d   = ctr_q - 1'b1;
            end
            StDone: begin
                pt_d     = {x_q, y_q};
                ready_d  = 1'b1;
                active_d = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ctr_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            k_q      <= '0;
            l_q      <= '0;
            pt_q     <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            k_q      <= k_d;
            l_q      <= l_d;
            pt_q     <= pt_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end

    // Round-key file carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (rk_we) rk[ctr_q] <= k_q;
    end

    assign bus.plaintext = pt_q;
    assign bus.active    = active_q;
    assign bus.ready     = ready_q;

endmodule
